led_pwm_seq: RTL and testbench



---
 rtl/led_pwm_seq_pkg.sv | 18 +
 rtl/led_pwm_gen.sv | 26 ++
 rtl/led_pwm_seq.sv | 152 +++++++++++++++
 tb/tb_led_pwm_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_seq_pkg.sv
// led_seq_pkg: shared types for the LED pattern sequencer.
//   mode_t : requested/active LED pattern (encoding matches the `mode` input)
//   dir_t  : sweep direction used by SCAN and BREATHE
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: free-running PWM counter with a duty comparator.
//   clk, rst_n : clock, asynchronous active-low reset
//   duty       : on-time in counts out of a 2^PWM_W period
//   pwm_on     : high while the counter is below duty (combinational from the counter flop)
module led_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on
);

  localparam logic [PWM_W-1:0] CTR_ONE = PWM_W'(1);

  logic [PWM_W-1:0] pwm_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_ctr <= '0;
    else        pwm_ctr <= pwm_ctr + CTR_ONE;
  end

  // duty=0 never lights; the all-ones duty leaves exactly one dark count per period.
  assign pwm_on = (pwm_ctr < duty);

endmodule

// File: rtl/led_pwm_seq.sv
// led_pwm_seq: LED pattern sequencer with global PWM brightness.
//   clk, rst_n  : clock from the input buffer, asynchronous active-low reset
//   mode        : requested pattern (0 BINARY, 1 SCAN, 2 BREATHE, 3 OFF)
//   mode_load   : one-cycle strobe capturing `mode` as pending; applied at the next step tick
//   brightness  : global duty ceiling, sampled every clock
//   leds        : registered LED drive
//   step_tick   : one-cycle pulse per pattern step
// Build option: define LED_ACTIVE_LOW_EN to invert `leds` at the output register
// (reset value becomes all ones so LEDs stay dark on active-low boards).
//
// Pattern FSM (state = active_mode)
//   state        | meaning
//   MODE_BINARY  | pattern counts up by one per step, wrapping
//   MODE_SCAN    | single lit bit bouncing between bit0 and the MSB
//   MODE_BREATHE | all LEDs lit, breath_lvl ramps 0..max..0 to modulate duty
//   MODE_OFF     | pattern held at zero
module led_pwm_seq
  import led_seq_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int STEP_DIV = 1000000,
  parameter int PWM_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             mode_load,
  input  logic [PWM_W-1:0] brightness,
  output logic [N_LED-1:0] leds,
  output logic             step_tick
);

  localparam int               CTR_W     = $clog2(STEP_DIV);
  localparam logic [CTR_W-1:0] STEP_LAST = CTR_W'(STEP_DIV - 1);
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [PWM_W-1:0] LVL_MAX   = '1;
  localparam logic [PWM_W-1:0] LVL_ONE   = PWM_W'(1);
  localparam logic [N_LED-1:0] PAT_ONE   = N_LED'(1);

  logic [CTR_W-1:0]   step_ctr;
  mode_t              active_mode;
  mode_t              pending_mode;
  mode_t              next_pending;
  dir_t               dir;
  logic [N_LED-1:0]   pattern;
  logic [PWM_W-1:0]   breath_lvl;
  logic [2*PWM_W-1:0] breath_prod;
  logic [PWM_W-1:0]   duty;
  logic               pwm_on;

  // A load coincident with a tick must take effect at that same tick,
  // so the FSM looks at the value pending_mode is about to take.
  always_comb begin
    next_pending = pending_mode;
    if (mode_load) next_pending = mode_t'(mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_ctr  <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= (step_ctr == STEP_LAST);
      if (step_ctr == STEP_LAST) step_ctr <= '0;
      else                       step_ctr <= step_ctr + CTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_mode <= MODE_BINARY;
      active_mode  <= MODE_BINARY;
      pattern      <= '0;
      breath_lvl   <= '0;
      dir          <= DIR_UP;
    end else begin
      pending_mode <= next_pending;
      if (step_tick) begin
        active_mode <= next_pending;
        if (next_pending != active_mode) begin
          // Mode change: re-initialise only; the first real step is at the next tick.
          case (next_pending)
            MODE_SCAN: begin
              pattern <= PAT_ONE;
              dir     <= DIR_UP;
            end
            MODE_BREATHE: begin
              pattern    <= '1;
              breath_lvl <= '0;
              dir        <= DIR_UP;
            end
            default: pattern <= '0;
          endcase
        end else begin
          case (active_mode)
            MODE_BINARY: pattern <= pattern + PAT_ONE;
            MODE_SCAN: begin
              // Direction flips as the end bit is reached, so each end is lit for one step.
              if (dir == DIR_UP) begin
                pattern <= pattern << 1;
                if (pattern[N_LED-2]) dir <= DIR_DOWN;
              end else begin
                pattern <= pattern >> 1;
                if (pattern[1]) dir <= DIR_UP;
              end
            end
            MODE_BREATHE: begin
              if (dir == DIR_UP) begin
                breath_lvl <= breath_lvl + LVL_ONE;
                if (breath_lvl == LVL_MAX - LVL_ONE) dir <= DIR_DOWN;
              end else begin
                breath_lvl <= breath_lvl - LVL_ONE;
                if (breath_lvl == LVL_ONE) dir <= DIR_UP;
              end
            end
            default: pattern <= '0;
          endcase
        end
      end
    end
  end

  // Breathing level scales the brightness ceiling; the high half of the product is the duty.
  assign breath_prod = breath_lvl * brightness;
  assign duty = (active_mode == MODE_BREATHE) ? breath_prod[2*PWM_W-1:PWM_W] : brightness;

  led_pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty   (duty),
    .pwm_on (pwm_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LED_ACTIVE_LOW_EN
      leds <= '1;
`else
      leds <= '0;
`endif
    end else begin
`ifdef LED_ACTIVE_LOW_EN
      leds <= ~(pattern & {N_LED{pwm_on}});
`else
      leds <= pattern & {N_LED{pwm_on}};
`endif
    end
  end

endmodule

// File: tb/tb_led_pwm_seq.sv
module tb_led_pwm_seq;

  localparam int N = 8;
  localparam int D = 4;
  localparam int W = 4;
  localparam int P = 16;

  logic         clk;
  logic         rst_n;
  logic [1:0]   mode;
  logic         mode_load;
  logic [W-1:0] brightness;
  logic [N-1:0] leds;
  logic         step_tick;

  int n_pass  = 0;
  int n_total = 0;

  led_pwm_seq #(.N_LED(N), .STEP_DIV(D), .PWM_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .mode_load  (mode_load),
    .brightness (brightness),
    .leds       (leds),
    .step_tick  (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (step-index based) ----------------
  int       m_e;        // clock edges since reset release
  int       m_pending;
  int       m_active;
  int       m_k;        // steps taken in the current mode
  logic     m_tick;
  logic [N-1:0] m_leds;

  function automatic logic [N-1:0] outv(input logic [N-1:0] x);
`ifdef LED_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  function automatic int lvl_of(input int k);
    int q;
    q = k % (2 * (P - 1));
    return (q <= P - 1) ? q : 2 * (P - 1) - q;
  endfunction

  function automatic logic [N-1:0] pat_of(input int m, input int k);
    int p, idx;
    case (m)
      0: return N'(k % (1 << N));
      1: begin
        p   = k % (2 * (N - 1));
        idx = (p < N) ? p : 2 * (N - 1) - p;
        return N'(1 << idx);
      end
      2: return '1;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_e = 0; m_pending = 0; m_active = 0; m_k = 0; m_tick = 1'b0; m_leds = '0;
  endtask

  task automatic model_step(input int md, input bit ld, input int br);
    int pwm, duty, nxt;
    logic [N-1:0] nl;
    pwm  = m_e % P;
    duty = (m_active == 2) ? (lvl_of(m_k) * br) / P : br;
    nl   = (pwm < duty) ? pat_of(m_active, m_k) : '0;
    nxt  = ld ? md : m_pending;
    if (m_tick) begin
      if (nxt != m_active) begin m_active = nxt; m_k = 0; end
      else m_k = m_k + 1;
    end
    m_pending = nxt;
    m_e = m_e + 1;
    m_tick = (m_e % D == 0);
    m_leds = nl;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Called at a negedge: drive, take one clock, compare at the next negedge.
  task automatic cyc(input int md, input bit ld, input int br, input bit do_chk);
    mode = 2'(md); mode_load = ld; brightness = W'(br);
    @(posedge clk);
    model_step(md, ld, br);
    @(negedge clk);
    mode_load = 1'b0;
    if (do_chk) begin
      chk("leds", 32'(leds), 32'(outv(m_leds)));
      chk("step_tick", 32'(step_tick), 32'(m_tick));
    end
  endtask

  // OR of the (active-high) LED image over one full step window.
  task automatic step_image(input int md, input int br, output logic [N-1:0] img);
    img = '0;
    for (int c = 0; c < D; c++) begin
      cyc(md, 1'b0, br, 1'b1);
      img = img | outv(leds);
    end
  endtask

  task automatic align_to_tick(input int md, input int br);
    int guard;
    guard = 0;
    while ((m_e % D) != 0 && guard < 2 * D) begin
      cyc(md, 1'b0, br, 1'b1);
      guard++;
    end
    chk("align_bound", 32'(m_e % D), 32'd0);
  endtask

  typedef struct {
    logic [1:0]   md;
    logic         ld;
    logic [W-1:0] br;
    logic [N-1:0] exp_leds;
    logic         exp_tick;
  } vec_t;

  vec_t vecs[18];
  logic [N-1:0] scan_exp[16];

  initial begin
    logic [N-1:0] img;
    int cnt;

    // Hand-derived: BINARY after reset, brightness 15 (on for pwm 0..14), tick every 4 clocks.
    vecs[0]  = '{0, 0, 15, 8'h00, 0};  vecs[1]  = '{0, 0, 15, 8'h00, 0};
    vecs[2]  = '{0, 0, 15, 8'h00, 0};  vecs[3]  = '{0, 0, 15, 8'h00, 1};
    vecs[4]  = '{0, 0, 15, 8'h00, 0};  vecs[5]  = '{0, 0, 15, 8'h01, 0};
    vecs[6]  = '{0, 0, 15, 8'h01, 0};  vecs[7]  = '{0, 0, 15, 8'h01, 1};
    vecs[8]  = '{0, 0, 15, 8'h01, 0};  vecs[9]  = '{0, 0, 15, 8'h02, 0};
    vecs[10] = '{0, 0, 15, 8'h02, 0};  vecs[11] = '{0, 0, 15, 8'h02, 1};
    vecs[12] = '{0, 0, 15, 8'h02, 0};  vecs[13] = '{0, 0, 15, 8'h03, 0};
    vecs[14] = '{0, 0, 15, 8'h03, 0};  vecs[15] = '{0, 0, 15, 8'h00, 1};
    vecs[16] = '{0, 0, 15, 8'h03, 0};  vecs[17] = '{0, 0, 15, 8'h04, 0};

    scan_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    rst_n = 1'b0; mode = 2'd0; mode_load = 1'b0; brightness = W'(15);
    model_reset();
    #1;
    chk("reset_leds", 32'(leds), 32'(outv('0)));
    chk("reset_tick", 32'(step_tick), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].md, vecs[i].ld, vecs[i].br, 1'b0);
      chk("vec_leds", 32'(leds), 32'(outv(vecs[i].exp_leds)));
      chk("vec_tick", 32'(step_tick), 32'(vecs[i].exp_tick));
    end

    // BINARY wrap through all ones back to zero.
    for (int i = 0; i < 1100; i++) cyc(0, 1'b0, 15, 1'b1);

    // Load coincident with a tick applies at that tick; then the SCAN bounce sequence.
    align_to_tick(0, 15);
    cyc(1, 1'b1, 15, 1'b1);
    for (int s = 0; s < 16; s++) begin
      step_image(1, 15, img);
      chk("scan_seq", 32'(img), 32'(scan_exp[s]));
    end

    // Handshake: SCAN 3 clocks before tick, BINARY 1 clock before -> BINARY, pattern 0.
    align_to_tick(1, 15);
    cyc(1, 1'b1, 15, 1'b1);
    cyc(1, 1'b0, 15, 1'b1);
    cyc(0, 1'b1, 15, 1'b1);
    cyc(0, 1'b0, 15, 1'b1);
    chk("hs_tick", 32'(step_tick), 32'd1);
    cyc(0, 1'b0, 15, 1'b1);
    step_image(0, 15, img);
    chk("hs_binary", 32'(img), 32'd0);

    // BREATHE through a full 0..15..0 ramp and beyond.
    cyc(2, 1'b1, 15, 1'b1);
    for (int i = 0; i < 260; i++) cyc(2, 1'b0, 15, 1'b1);

    // Asynchronous reset mid-run between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_leds", 32'(leds), 32'(outv('0)));
    chk("midrst_tick", 32'(step_tick), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 3 * D) begin
      cyc(0, 1'b0, 15, 1'b1);
      cnt++;
      if (step_tick) break;
    end
    chk("first_tick_latency", 32'(cnt), 32'(D));

    // brightness 0: dark in every mode.
    for (int i = 0; i < 48; i++) begin
      cyc(i / 12, (i % 12) == 0, 0, 1'b1);
      chk("bright0", 32'(leds), 32'(outv('0)));
    end

    // Randomized mix of modes, loads and brightness.
    brightness = W'($urandom_range(0, P - 1));
    for (int i = 0; i < 3000; i++) begin
      int br;
      br = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, P - 1)) : int'(brightness);
      cyc($urandom_range(0, 3), ($urandom_range(0, 15) == 0), br, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
